// File: rtl/vsync_cnt.sv
// Vertical timing counter for 640x480@60 VGA: advances the row once per line
// and produces registered vsync / rgb_en aligned with the row register.
module vsync_cnt #(
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] column,
  output logic        vsync,
  output logic        rgb_en,
  output logic [10:0] row
);

  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] LINE_END   = 11'(H_TOTAL);
  localparam logic [10:0] ROW_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] VIS_END    = 11'(V_VISIBLE);
  localparam logic [10:0] SYNC_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic RGB_EN_RST = (V_VISIBLE > 0) ? 1'b1 : 1'b0;

  logic [10:0] row_q, row_d;
  logic        vsync_q, vsync_d;
  logic        rgb_en_q, rgb_en_d;

  // Next row and its decode; outputs are decoded from row_d so they land
  // in the same cycle as the row they describe.
  always_comb begin
    row_d = row_q;
    if (column == LINE_END) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 11'd1;
    end
    rgb_en_d = (row_d < VIS_END);
    vsync_d  = ((row_d >= SYNC_START) && (row_d < SYNC_END)) ? VSYNC_ACTIVE
                                                             : ~VSYNC_ACTIVE;
  end

  // State registers with synchronous reset to the top of frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q    <= '0;
      vsync_q  <= ~VSYNC_ACTIVE;
      rgb_en_q <= RGB_EN_RST;
    end else begin
      row_q    <= row_d;
      vsync_q  <= vsync_d;
      rgb_en_q <= rgb_en_d;
    end
  end

  assign row    = row_q;
  assign vsync  = vsync_q;
  assign rgb_en = rgb_en_q;

endmodule

// File: tb/tb_vsync_cnt.sv
// Directed bench for vsync_cnt at default VGA timing.
module tb_vsync_cnt;

  logic        clk;
  logic        rst;
  logic [10:0] column;
  logic        vsync;
  logic        rgb_en;
  logic [10:0] row;

  int checks;
  int errors;

  vsync_cnt #(
    .H_TOTAL     (800),
    .V_VISIBLE   (480),
    .V_FRONT     (10),
    .V_SYNC      (2),
    .V_BACK      (33),
    .VSYNC_ACTIVE(1'b0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .column(column),
    .vsync (vsync),
    .rgb_en(rgb_en),
    .row   (row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic [10:0] c);
    rst    = r;
    column = c;
    @(posedge clk);
    #1;
  endtask

  // Hand-computed output levels at the boundary rows of interest.
  task automatic check_boundary(input int unsigned r);
    case (r)
      0:   begin check("rgb_row0",   rgb_en, 1); check("vs_row0",   vsync, 1); end
      479: begin check("rgb_row479", rgb_en, 1); check("vs_row479", vsync, 1); end
      480: begin check("rgb_row480", rgb_en, 0); check("vs_row480", vsync, 1); end
      489: begin check("rgb_row489", rgb_en, 0); check("vs_row489", vsync, 1); end
      490: begin check("rgb_row490", rgb_en, 0); check("vs_row490", vsync, 0); end
      491: begin check("rgb_row491", rgb_en, 0); check("vs_row491", vsync, 0); end
      492: begin check("rgb_row492", rgb_en, 0); check("vs_row492", vsync, 1); end
      524: begin check("rgb_row524", rgb_en, 0); check("vs_row524", vsync, 1); end
      default: ;
    endcase
  endtask

  int unsigned exp_row;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    column = 11'd800;

    // Reset with column at line end: reset must win.
    step(1'b1, 11'd800);
    step(1'b1, 11'd800);
    check("rst_row", row, 0);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", rgb_en, 1);

    // Columns below line end never advance.
    for (int unsigned c = 0; c < 800; c++) begin
      step(1'b0, 11'(c));
      check("hold_row", row, 0);
      check("hold_vsync", vsync, 1);
      check("hold_rgb", rgb_en, 1);
    end

    // Columns above line end never advance.
    step(1'b0, 11'd801);
    check("above_801", row, 0);
    step(1'b0, 11'd2047);
    check("above_2047", row, 0);

    // Consecutive cycles at line end: 650 advances, wrapping once to 125.
    exp_row = 0;
    for (int unsigned i = 0; i < 650; i++) begin
      step(1'b0, 11'd800);
      exp_row = (exp_row == 524) ? 0 : exp_row + 1;
      check("adv_row", row, exp_row);
      check_boundary(exp_row);
    end
    check("wrap_end", row, 125);

    // Single advance between idle columns.
    step(1'b0, 11'd5);
    check("idle_hold", row, 125);
    step(1'b0, 11'd800);
    check("single_adv", row, 126);

    // Mid-frame reset at row 300.
    step(1'b1, 11'd0);
    for (int unsigned i = 0; i < 300; i++) step(1'b0, 11'd800);
    check("pre_mid_rst", row, 300);
    check("pre_mid_rgb", rgb_en, 1);
    step(1'b1, 11'd800);
    check("mid_rst_row", row, 0);
    check("mid_rst_vsync", vsync, 1);
    check("mid_rst_rgb", rgb_en, 1);
    step(1'b0, 11'd800);
    check("resume_row", row, 1);
    step(1'b0, 11'd800);
    check("resume_row2", row, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vsync_cnt.md
Name: vsync_cnt

Overview:
Vertical timing counter for the 640x480 @ 60 Hz VGA controller, clocked at the 25 MHz pixel clock. It consumes the horizontal column count from the horizontal counter and advances the row count once per line. It generates the vertical sync pulse and the vertical component of the RGB enable (display-active) signal. It sits beside the horizontal counter; its outputs feed the RGB output stage and the VGA connector.

Parameters:
H_TOTAL, 800, column value that marks end of line; row advances on each clock where column == H_TOTAL
V_VISIBLE, 480, visible rows (0..V_VISIBLE-1)
V_FRONT, 10, front-porch rows after visible region
V_SYNC, 2, sync-pulse rows
V_BACK, 33, back-porch rows; V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK = 525
VSYNC_ACTIVE, 0, level of vsync during the sync pulse (0 = active-low)

Ports:
clk  input  1  pixel clock, 25 MHz; all state updates on rising edge
rst  input  1  synchronous, active-high reset
column  input  11  current horizontal position from horizontal counter, unsigned
vsync  output  1  vertical sync, registered
rgb_en  output  1  vertical display-enable, high while row is in visible region, registered
row  output  11  current row, unsigned, range 0..V_TOTAL-1, registered

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled on the rising clk edge only.
- Reset state (rst high at a clk edge): row = 0, vsync = 1 (inactive), rgb_en = 1 (row 0 is visible). Reset has priority over counting. Mid-frame reset returns to this state on the next edge.
- Line advance: on a clk edge with rst low and column == H_TOTAL, row <= row + 1.
  - If row == V_TOTAL-1 (524), row <= 0 instead (wrap).
  - If column != H_TOTAL, row holds.
  - column held at H_TOTAL for consecutive cycles advances row every cycle (no edge detection).
- Column values above H_TOTAL never advance row.
- Decode is registered and computed from the next row value, so vsync and rgb_en always match row in the same cycle (zero skew, no combinational path from column to outputs).
  - rgb_en = 1 when row < V_VISIBLE (0..479), else 0.
  - vsync = VSYNC_ACTIVE when V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC (rows 490..491), else the inverse level (1 for defaults).
- Arithmetic: 11-bit unsigned throughout. The row increment cannot overflow because of the wrap at V_TOTAL-1.
- No X propagation: all outputs are defined from the first reset edge onward.

Test Plan:
- Reset: rst=1, column=800, sample before the first post-reset increment -> row=0, vsync=1, rgb_en=1.
- Hold: rst=0, column=0..799 for 800 cycles -> row stays 0; vsync=1 and rgb_en=1 throughout.
- Visible boundary: column held at 800, count edges -> row=479 gives rgb_en=1; row=480 gives rgb_en=0; vsync=1 at both.
- Sync pulse: continue counting -> vsync=1 at row 489; vsync=0 at rows 490 and 491; vsync=1 at row 492; rgb_en=0 throughout.
- Wrap: column=800 for 650 cycles after reset release -> row reaches 524, then 0 on the next advance (rgb_en returns to 1), then ends at row 125.
- Mid-frame reset: assert rst at row=300 with column=800 -> next edge gives row=0, vsync=1, rgb_en=1; counting resumes after rst drops.
